// File: rtl/seq_detect_pkg.sv
// Shared types and default sizing for the serial pattern detector.
package seq_detect_pkg;

  localparam int W_DEF     = 8;
  localparam int LEN_W_DEF = $clog2(W_DEF + 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    FILL = 2'b01,
    RUN  = 2'b10
  } state_e;

  typedef struct packed {
    logic [W_DEF-1:0]     pat;
    logic [LEN_W_DEF-1:0] len;
  } cfg_t;

endpackage

// File: rtl/seq_match.sv
// Shift register plus masked compare; match looks at the value about to be shifted in.
module seq_match
  import seq_detect_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int LEN_W = $clog2(W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             in,
  input  logic [W-1:0]     pat,
  input  logic [LEN_W-1:0] len,
  output logic             match
);

  logic [W-1:0] shift;
  logic [W-1:0] shift_next;
  logic [W-1:0] mask;

  always_comb begin
    shift_next = shift_en ? {shift[W-2:0], in} : shift;
  end

  always_comb begin
    mask = '0;
    for (int i = 0; i < W; i++) begin
      mask[i] = (i < int'(len));
    end
  end

  assign match = (((shift_next ^ pat) & mask) == '0);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      shift <= '0;
    end else begin
      shift <= shift_next;
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Configurable serial pattern detector: config port, arm/disarm FSM, fill gate, hit counter.
//   state | meaning
//   IDLE  | waiting for config or start
//   FILL  | armed, fewer than len beats received
//   RUN   | armed, matching on every beat
module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int CNT_W = 8,
  parameter int LEN_W = $clog2(W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_vld,
  input  logic [W-1:0]     cfg_pat,
  input  logic [LEN_W-1:0] cfg_len,
  output logic             cfg_rdy,
  input  logic             cmd_start,
  input  logic             cmd_stop,
  input  logic             in_vld,
  input  logic             in,
  output logic             hit,
  output logic [CNT_W-1:0] hit_cnt,
  output logic             busy,
  output logic             err
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_FILL = FILL;
  localparam logic [1:0] S_RUN  = RUN;

  logic [1:0]       state;
  logic [1:0]       state_dec;
  logic [1:0]       state_nxt;
  logic [W-1:0]     pat_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] fill;
  logic [LEN_W-1:0] fill_inc;
  logic             cfg_valid;
  logic             idle;
  logic             cfg_hs;
  logic             cfg_ok;
  logic             cfg_take;
  logic             start_ok;
  logic             shift_en;
  logic             reach;
  logic             match;
  logic             hit_d;
  logic             err_d;

  // Unused encoding 2'b11 behaves as IDLE everywhere.
  assign state_dec = (state == S_FILL || state == S_RUN) ? state : S_IDLE;
  assign idle      = (state_dec == S_IDLE);
  assign cfg_rdy   = idle;
  assign busy      = !idle;

  assign cfg_hs   = cfg_vld && cfg_rdy;
  assign cfg_ok   = (cfg_len != '0) && (cfg_len <= LEN_W'(W));
  assign cfg_take = cfg_hs && cfg_ok;
  assign start_ok = idle && cmd_start && !cmd_stop && !cfg_hs && cfg_valid;
  assign err_d    = (cfg_hs && !cfg_ok) ||
                    (idle && cmd_start && !cmd_stop && !cfg_hs && !cfg_valid);

  // A beat arriving together with stop is dropped entirely.
  assign shift_en = !idle && in_vld && !cmd_stop;
  assign fill_inc = fill + LEN_W'(1);
  assign reach    = (state_dec == S_FILL) && shift_en && (fill_inc == len_q);
  assign hit_d    = shift_en && ((state_dec == S_RUN) || reach) && match;

  always_comb begin
    state_nxt = state_dec;
    case (state_dec)
      S_IDLE:  if (start_ok) state_nxt = S_FILL;
      S_FILL:  if (cmd_stop) state_nxt = S_IDLE;
               else if (reach) state_nxt = S_RUN;
      S_RUN:   if (cmd_stop) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  seq_match #(.W(W), .LEN_W(LEN_W)) u_match (
    .clk      (clk),
    .rst      (rst),
    .clr      (start_ok),
    .shift_en (shift_en),
    .in       (in),
    .pat      (pat_q),
    .len      (len_q),
    .match    (match)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      pat_q     <= '0;
      len_q     <= '0;
      cfg_valid <= 1'b0;
      fill      <= '0;
      hit       <= 1'b0;
      hit_cnt   <= '0;
      err       <= 1'b0;
    end else begin
      state <= state_nxt;
      hit   <= hit_d;
      err   <= err_d;
      if (cfg_take) begin
        pat_q     <= cfg_pat;
        len_q     <= cfg_len;
        cfg_valid <= 1'b1;
      end
      if (start_ok) begin
        fill <= '0;
      end else if (state_dec == S_FILL && shift_en) begin
        fill <= fill_inc;
      end
      if (cfg_take || start_ok) begin
        hit_cnt <= '0;
      end else if (hit_d && hit_cnt != '1) begin
        hit_cnt <= hit_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Scoreboard bench for seq_detect_ctrl; a second instance with a 2-bit counter shares all stimulus.
module tb_seq_detect_ctrl;

  localparam int W     = 8;
  localparam int LEN_W = $clog2(W + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_vld;
  logic [W-1:0]     cfg_pat;
  logic [LEN_W-1:0] cfg_len;
  logic             cmd_start;
  logic             cmd_stop;
  logic             in_vld;
  logic             in_bit;

  logic             cfg_rdy, hit, busy, err;
  logic [7:0]       hit_cnt;
  logic             cfg_rdy_s, hit_s, busy_s, err_s;
  logic [1:0]       hit_cnt_s;

  int checks = 0;
  int passed = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  seq_detect_ctrl #(.W(W), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .cfg_vld(cfg_vld), .cfg_pat(cfg_pat), .cfg_len(cfg_len),
    .cfg_rdy(cfg_rdy), .cmd_start(cmd_start), .cmd_stop(cmd_stop), .in_vld(in_vld),
    .in(in_bit), .hit(hit), .hit_cnt(hit_cnt), .busy(busy), .err(err)
  );

  seq_detect_ctrl #(.W(W), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .cfg_vld(cfg_vld), .cfg_pat(cfg_pat), .cfg_len(cfg_len),
    .cfg_rdy(cfg_rdy_s), .cmd_start(cmd_start), .cmd_stop(cmd_stop), .in_vld(in_vld),
    .in(in_bit), .hit(hit_s), .hit_cnt(hit_cnt_s), .busy(busy_s), .err(err_s)
  );

  // One clock: expected hit is queued with the beat, popped once the edge has passed.
  task automatic step(input logic v, input logic b, input logic exp_hit);
    logic e;
    in_vld = v;
    in_bit = b;
    exp_q.push_back(exp_hit);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    checks++;
    if (hit !== e || hit_s !== e)
      $display("FAIL hit: got %b/%b expected %b at %0t", hit, hit_s, e, $time);
    else passed++;
    cfg_vld = 1'b0; cmd_start = 1'b0; cmd_stop = 1'b0; in_vld = 1'b0; rst = 1'b0;
  endtask

  task automatic do_cfg(input logic [W-1:0] p, input logic [LEN_W-1:0] l);
    cfg_vld = 1'b1; cfg_pat = p; cfg_len = l;
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_start();
    cmd_start = 1'b1;
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_stop();
    cmd_stop = 1'b1;
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (cfg_rdy !== 1'b1) $display("FAIL reset_cfg_rdy: got %b expected 1", cfg_rdy); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
    checks++; if (err !== 1'b0) $display("FAIL reset_err: got %b expected 0", err); else passed++;
    checks++; if (hit_cnt !== 8'd0) $display("FAIL reset_cnt: got %0d expected 0", hit_cnt); else passed++;
  endtask

  task automatic test_full_pattern();
    logic [7:0] bits = 8'b10011010;
    do_cfg(8'b10011010, 4'd8);
    checks++; if (err !== 1'b0) $display("FAIL full_cfg_err: got %b expected 0", err); else passed++;
    do_start();
    for (int i = 7; i >= 0; i--) begin
      step(1'b1, bits[i], (i == 0));
      checks++; if (busy !== 1'b1) $display("FAIL full_busy: got %b expected 1", busy); else passed++;
    end
    step(1'b0, 1'b0, 1'b0);
    checks++; if (hit_cnt !== 8'd1) $display("FAIL full_cnt: got %0d expected 1", hit_cnt); else passed++;
    do_stop();
  endtask

  task automatic test_overlap();
    logic [4:0] bits = 5'b10101;
    logic [4:0] exp  = 5'b00101;
    do_cfg(8'b00000101, 4'd3);
    do_start();
    for (int i = 4; i >= 0; i--) step(1'b1, bits[i], exp[i]);
    checks++; if (hit_cnt !== 8'd2) $display("FAIL overlap_cnt: got %0d expected 2", hit_cnt); else passed++;
    do_stop();
    checks++; if (busy !== 1'b0) $display("FAIL overlap_stop_busy: got %b expected 0", busy); else passed++;
  endtask

  task automatic test_illegal();
    do_reset();
    do_cfg(8'h01, 4'd0);
    checks++; if (err !== 1'b1) $display("FAIL illegal_len0_err: got %b expected 1", err); else passed++;
    step(1'b0, 1'b0, 1'b0);
    checks++; if (err !== 1'b0) $display("FAIL illegal_err_pulse: got %b expected 0", err); else passed++;
    do_cfg(8'h01, 4'd9);
    checks++; if (err !== 1'b1) $display("FAIL illegal_len9_err: got %b expected 1", err); else passed++;
    do_start();
    checks++; if (err !== 1'b1) $display("FAIL illegal_start_err: got %b expected 1", err); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL illegal_start_busy: got %b expected 0", busy); else passed++;
  endtask

  task automatic test_gap_and_restart();
    do_cfg(8'b00000101, 4'd3);
    do_start();
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    checks++; if (hit_cnt !== 8'd1) $display("FAIL gap_cnt: got %0d expected 1", hit_cnt); else passed++;
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    do_stop();
    do_start();
    step(1'b1, 1'b1, 1'b0);
    checks++; if (hit_cnt !== 8'd0) $display("FAIL restart_cnt: got %0d expected 0", hit_cnt); else passed++;
    do_stop();
  endtask

  task automatic test_saturate();
    do_cfg(8'b00000001, 4'd1);
    do_start();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b1);
    checks++; if (hit_cnt_s !== 2'd3) $display("FAIL sat_cnt: got %0d expected 3", hit_cnt_s); else passed++;
    checks++; if (hit_cnt !== 8'd6) $display("FAIL wide_cnt: got %0d expected 6", hit_cnt); else passed++;
    do_stop();
  endtask

  task automatic test_stop_on_complete();
    do_cfg(8'b00000101, 4'd3);
    do_start();
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    cmd_stop = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    checks++; if (busy !== 1'b0) $display("FAIL stopc_busy: got %b expected 0", busy); else passed++;
    checks++; if (hit_cnt !== 8'd0) $display("FAIL stopc_cnt: got %0d expected 0", hit_cnt); else passed++;
  endtask

  task automatic test_cfg_with_start();
    do_reset();
    cmd_start = 1'b1;
    do_cfg(8'b00000011, 4'd2);
    checks++; if (err !== 1'b0) $display("FAIL cfgstart_err: got %b expected 0", err); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL cfgstart_busy: got %b expected 0", busy); else passed++;
    do_start();
    checks++; if (busy !== 1'b1) $display("FAIL cfgstart_armed: got %b expected 1", busy); else passed++;
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    do_stop();
  endtask

  initial begin
    rst = 1'b1; cfg_vld = 1'b0; cfg_pat = '0; cfg_len = '0;
    cmd_start = 1'b0; cmd_stop = 1'b0; in_vld = 1'b0; in_bit = 1'b0;
    test_reset();
    test_full_pattern();
    test_overlap();
    test_illegal();
    test_gap_and_restart();
    test_saturate();
    test_stop_on_complete();
    test_cfg_with_start();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
Run-time configurable serial pattern detector with its own controller, for the bit-serial monitor path. It accepts a pattern and a length over a valid/ready config port, and is armed and disarmed by start/stop commands. It gates an internal shift-register matcher so that no hit fires before enough bits have arrived, and it counts overlapping matches. It sits between a host/config agent and a qualified serial bit stream.

Parameters:
W, 8, maximum pattern length in bits (W >= 2)
CNT_W, 8, width of the saturating hit counter
LEN_W, $clog2(W+1), width of the length field (derived; do not override)

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  synchronous, active-high reset
cfg_vld  in  1  config offer
cfg_pat  in  W  pattern; cfg_pat[len-1] is the first bit received, cfg_pat[0] the last
cfg_len  in  LEN_W  pattern length; legal range 1..W
cfg_rdy  out  1  config accepted when cfg_vld & cfg_rdy
cmd_start  in  1  arm the detector
cmd_stop  in  1  disarm the detector
in_vld  in  1  serial beat qualifier
in  in  1  serial data bit
hit  out  1  one-cycle pulse per match
hit_cnt  out  CNT_W  saturating match count
busy  out  1  state != IDLE
err  out  1  one-cycle pulse on an illegal config or command

Behaviour:
- Reset values: state IDLE, cfg_rdy=1, hit=0, hit_cnt=0, busy=0, err=0, cfg_valid flag=0, shift register=0, fill=0.
- States:
  - IDLE: waiting for config or start.
  - FILL: armed, fewer than len beats received.
  - RUN: armed, matching.
- Config, IDLE only:
  - cfg_rdy = (state==IDLE), combinational from state.
  - Handshake with 1<=cfg_len<=W: latch pattern and length, set cfg_valid, clear hit_cnt.
  - Handshake with cfg_len=0 or cfg_len>W: no latch, previous config retained, err pulses on the next cycle.
- Start:
  - IDLE & cmd_start & cfg_valid: go to FILL, clear shift register, fill and hit_cnt.
  - IDLE & cmd_start & !cfg_valid: err pulses, stay in IDLE.
  - cmd_start in FILL/RUN: ignored.
  - Config handshake and cmd_start in the same cycle: the config is taken, start is dropped, no err.
- Stop:
  - cmd_stop in FILL/RUN: go to IDLE next cycle. A beat in that cycle is discarded and produces no hit.
  - cmd_stop beats cmd_start when both are asserted; cmd_stop in IDLE is a no-op.
  - hit_cnt holds its value in IDLE.
- Shifting: on in_vld in FILL/RUN, shift_next = {shift[W-2:0], in}. Without in_vld the register holds.
- Fill:
  - In FILL, each beat increments fill.
  - The beat that makes fill == len moves to RUN in the same clock edge; for len=1 this is the first beat.
- Match:
  - match = ((shift_next ^ pat) & mask) == 0, where mask has the low len bits set.
  - Evaluated on every beat that leaves the block in RUN, including the FILL->RUN beat.
- Hit timing:
  - hit is registered: a beat at cycle N that completes the pattern gives hit=1 at N+1.
  - hit_cnt increments in that same edge, so the new value is visible at N+1.
  - Overlapping matches all count.
  - hit_cnt saturates at 2^CNT_W-1.
- Reset mid-operation: everything returns to reset values, including cfg_valid, so the block must be reconfigured.
- Illegal state encodings decode to IDLE.

Decomposition:
- Package seq_detect_pkg holds:
  - state enum (IDLE=2'b00, FILL=2'b01, RUN=2'b10)
  - cfg struct {pat, len}
  - W / LEN_W defaults
- Sub-module seq_match: shift register plus masked compare. Inputs: clk, rst, clr, shift_en, in, pat, len. Output: combinational match on the next shift value.
- seq_detect_ctrl owns the FSM, fill counter, hit register and counter.

Test Plan:
- Reset, cfg pat=8'b10011010 len=8, start, stream 1,0,0,1,1,0,1,0 on consecutive cycles -> hit=1 exactly once, one cycle after the 8th beat; hit_cnt=1; busy=1 throughout.
- pat=3'b101 len=3, stream 1,0,1,0,1 -> overlapping hits one cycle after beats 3 and 5; hit_cnt=2.
- cfg len=0, then len=9 (W=8) -> err pulse for each, cfg_valid stays 0. cmd_start -> err pulse, busy stays 0.
- len=3 pat=101, stream 1,0 then idle in_vld for 5 cycles then 1 -> one hit after the final beat. Stream with pattern split across a cmd_stop + cmd_start -> no hit, since the shift register is cleared on start.
- CNT_W=2, pat=1 len=1, stream six 1s -> hit pulses six times, hit_cnt saturates at 3.
- cmd_stop asserted on the completing beat -> no hit, state IDLE. Also check cfg_vld+cmd_start in the same IDLE cycle -> config taken, busy stays 0.
